// File: rtl/fatori_pkg.sv
// Shared types and helpers for the fatori voter family.
package fatori_pkg;

  typedef enum logic [1:0] {
    Q_ACTIVE = 2'd0,
    Q_QUAR   = 2'd1,
    Q_REJOIN = 2'd2
  } quar_state_e;

  // Agreement threshold: M = 0 selects a simple majority of the active replicas.
  function automatic int fatori_meff(input int active, input int m);
    if (m == 0) return active / 2 + 1;
    return m;
  endfunction

endpackage

// File: rtl/fatori_mon_quar_track.sv
// Per-replica quarantine tracker: mismatch counting, quarantine, scrub
// handshake and proven-agreement rejoin.
module fatori_mon_quar_track
  import fatori_pkg::*;
#(
  parameter int QUAR_TH    = 4,
  parameter int REJOIN_CYC = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mismatch_i,
  input  logic ack_i,
  input  logic allow_quar_i,
  output logic quar_cand_o,
  output logic masked_o,
  output logic masked_d_o,
  output logic req_o,
  output logic ack_taken_o
);

  localparam logic [3:0] QTH = 4'(QUAR_TH);
  localparam logic [7:0] RJC = 8'(REJOIN_CYC);

  quar_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]  acnt_q, acnt_d, acnt_inc;
  logic        req_q, req_d;

  // Saturate at the threshold so an inhibited replica retries every cycle.
  assign cnt_inc  = (cnt_q >= QTH) ? QTH : cnt_q + 4'd1;
  assign acnt_inc = acnt_q + 8'd1;

  assign quar_cand_o = (state_q == Q_ACTIVE) && mismatch_i && (cnt_inc == QTH);
  assign ack_taken_o = (state_q == Q_QUAR) && ack_i;
  assign masked_o    = (state_q != Q_ACTIVE);
  assign masked_d_o  = (state_d != Q_ACTIVE);
  assign req_o       = req_q;

  always_comb begin
    // NOTE: every _d signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    acnt_d  = acnt_q;
    req_d   = req_q;
    case (state_q)
      Q_ACTIVE: begin
        cnt_d = mismatch_i ? cnt_inc : 4'd0;
        if (quar_cand_o && allow_quar_i) begin
          state_d = Q_QUAR;
          req_d   = 1'b1;
        end
      end
      Q_QUAR: begin
        if (ack_i) begin
          state_d = Q_REJOIN;
          req_d   = 1'b0;
          acnt_d  = 8'd0;
        end
      end
      Q_REJOIN: begin
        if (mismatch_i) begin
          state_d = Q_QUAR;
          req_d   = 1'b1;
        end else if (acnt_inc == RJC) begin
          state_d = Q_ACTIVE;
          cnt_d   = 4'd0;
          acnt_d  = 8'd0;
        end else begin
          acnt_d = acnt_inc;
        end
      end
      default: state_d = Q_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking updates so all tracker registers see pre-edge values.
    if (rst_i) begin
      state_q <= Q_ACTIVE;
      cnt_q   <= 4'd0;
      acnt_q  <= 8'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acnt_q  <= acnt_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: rtl/fatori_mon_voter_quar.sv
// M-of-N bitwise voter with per-replica quarantine, scrub handshake and
// sticky error flags. The vote is combinational over the registered mask.
module fatori_mon_voter_quar
  import fatori_pkg::*;
#(
  parameter int W          = 32,
  parameter int N          = 3,
  parameter int M          = 0,
  parameter int HOLD       = 0,
  parameter int QUAR_TH    = 4,
  parameter int REJOIN_CYC = 8,
  parameter int MIN_ACTIVE = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N*W-1:0]         replicas_i,
  output logic [W-1:0]           y_o,
  output logic                   min_err_o,
  output logic                   maj_err_o,
  output logic [N-1:0]           scrub_req_o,
  input  logic [N-1:0]           scrub_ack_i,
  output logic [N-1:0]           quar_mask_o,
  output logic [$clog2(N+1)-1:0] active_cnt_o,
  output logic                   scrub_occurred_o,
  output logic [1:0]             err_sticky_o,
  input  logic                   clr_sticky_i
);

  localparam int CW          = $clog2(N+1);
  localparam int MIN_ACT_EFF = (MIN_ACTIVE < 1) ? ((N == 1) ? 1 : MIN_ACTIVE) : MIN_ACTIVE;

  logic [N-1:0]  mask_q, mask_d, mism, cand, allow, ack_taken;
  logic [CW-1:0] active_q, active_d;
  logic [W-1:0]  hold_q, vote_y;
  logic [1:0]    sticky_q;
  logic          occ_q, amb, room, granted, first_bit, found;
  int            meff, ones, zeros;

  for (genvar n = 0; n < N; n++) begin : g_trk
    assign mism[n] = (replicas_i[n*W +: W] != vote_y);
    fatori_mon_quar_track #(
      .QUAR_TH   (QUAR_TH),
      .REJOIN_CYC(REJOIN_CYC)
    ) u_trk (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .mismatch_i  (mism[n]),
      .ack_i       (scrub_ack_i[n]),
      .allow_quar_i(allow[n]),
      .quar_cand_o (cand[n]),
      .masked_o    (mask_q[n]),
      .masked_d_o  (mask_d[n]),
      .req_o       (scrub_req_o[n]),
      .ack_taken_o (ack_taken[n])
    );
  end

  always_comb begin
    meff      = (N == 1) ? 1 : fatori_meff(int'(active_q), M);
    vote_y    = hold_q;
    amb       = 1'b0;
    ones      = 0;
    zeros     = 0;
    first_bit = 1'b0;
    found     = 1'b0;
    for (int b = 0; b < W; b++) begin
      ones      = 0;
      zeros     = 0;
      first_bit = hold_q[b];
      found     = 1'b0;
      for (int n = 0; n < N; n++) begin
        if (!mask_q[n]) begin
          if (replicas_i[n*W + b]) ones++;
          else                     zeros++;
          if (!found) begin
            first_bit = replicas_i[n*W + b];
            found     = 1'b1;
          end
        end
      end
      if (ones >= meff)       vote_y[b] = 1'b1;
      else if (zeros >= meff) vote_y[b] = 1'b0;
      else begin
        amb       = 1'b1;
        vote_y[b] = (HOLD != 0) ? hold_q[b] : first_bit;
      end
    end
    if (active_q == '0) begin
      vote_y = hold_q;
      amb    = 1'b1;
    end
  end

  // Only the lowest-index candidate may leave per cycle; the room check uses
  // the pre-update active count.
  always_comb begin
    allow   = '0;
    granted = 1'b0;
    room    = (int'(active_q) - 1) >= MIN_ACT_EFF;
    for (int n = 0; n < N; n++) begin
      if (cand[n] && !granted) begin
        allow[n] = room;
        granted  = 1'b1;
      end
    end
  end

  always_comb begin
    active_d = '0;
    for (int n = 0; n < N; n++) active_d = active_d + CW'(!mask_d[n]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q   <= '0;
      sticky_q <= 2'b00;
      occ_q    <= 1'b0;
      active_q <= CW'(N);
    end else begin
      if (!maj_err_o) hold_q <= vote_y;
      sticky_q <= {maj_err_o | (sticky_q[1] & ~clr_sticky_i),
                   min_err_o | (sticky_q[0] & ~clr_sticky_i)};
      occ_q    <= |ack_taken;
      active_q <= active_d;
    end
  end

  assign y_o              = vote_y;
  assign maj_err_o        = amb;
  assign min_err_o        = !amb && |(mism & ~mask_q);
  assign quar_mask_o      = mask_q;
  assign active_cnt_o     = active_q;
  assign scrub_occurred_o = occ_q;
  assign err_sticky_o     = sticky_q;

endmodule

// File: tb/tb_fatori_mon_voter_quar.sv
// Directed bench: three voter configurations driven from one clock/reset.
module tb_fatori_mon_voter_quar;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // A: N=3, W=8, defaults
  logic [23:0] rep_a;
  logic [7:0]  y_a;
  logic        min_a, maj_a, occ_a, clr_a;
  logic [2:0]  req_a, ack_a, mask_a;
  logic [1:0]  act_a, stk_a;
  // B: N=5, W=8, MIN_ACTIVE=4
  logic [39:0] rep_b;
  logic [7:0]  y_b;
  logic        min_b, maj_b, occ_b;
  logic [4:0]  req_b, mask_b;
  logic [2:0]  act_b;
  logic [1:0]  stk_b;
  // C: N=2, W=8, HOLD=1
  logic [15:0] rep_c;
  logic [7:0]  y_c;
  logic        min_c, maj_c, occ_c, clr_c;
  logic [1:0]  req_c, mask_c, act_c, stk_c;

  fatori_mon_voter_quar #(.W(8), .N(3)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .replicas_i(rep_a), .y_o(y_a),
    .min_err_o(min_a), .maj_err_o(maj_a), .scrub_req_o(req_a),
    .scrub_ack_i(ack_a), .quar_mask_o(mask_a), .active_cnt_o(act_a),
    .scrub_occurred_o(occ_a), .err_sticky_o(stk_a), .clr_sticky_i(clr_a)
  );

  fatori_mon_voter_quar #(.W(8), .N(5), .MIN_ACTIVE(4)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .replicas_i(rep_b), .y_o(y_b),
    .min_err_o(min_b), .maj_err_o(maj_b), .scrub_req_o(req_b),
    .scrub_ack_i(5'b0), .quar_mask_o(mask_b), .active_cnt_o(act_b),
    .scrub_occurred_o(occ_b), .err_sticky_o(stk_b), .clr_sticky_i(1'b0)
  );

  fatori_mon_voter_quar #(.W(8), .N(2), .HOLD(1)) u_dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .replicas_i(rep_c), .y_o(y_c),
    .min_err_o(min_c), .maj_err_o(maj_c), .scrub_req_o(req_c),
    .scrub_ack_i(2'b0), .quar_mask_o(mask_c), .active_cnt_o(act_c),
    .scrub_occurred_o(occ_c), .err_sticky_o(stk_c), .clr_sticky_i(clr_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic probe();
    @(negedge clk_i);
  endtask

  initial begin
    rep_a = {3{8'hA5}}; ack_a = 3'b000; clr_a = 1'b0;
    rep_b = {5{8'h3C}};
    rep_c = {2{8'h33}}; clr_c = 1'b0;
    repeat (2) step();
    rst_i = 1'b0;

    // Reset state and clean vote on A
    probe();
    check("a_rst_y", 32'(y_a), 32'hA5);
    check("a_rst_min", 32'(min_a), 32'h0);
    check("a_rst_maj", 32'(maj_a), 32'h0);
    check("a_rst_active", 32'(act_a), 32'd3);
    check("a_rst_mask", 32'(mask_a), 32'h0);
    check("a_rst_req", 32'(req_a), 32'h0);
    check("a_rst_sticky", 32'(stk_a), 32'h0);
    check("a_rst_occ", 32'(occ_a), 32'h0);
    step();

    // Replica 1 faulty for four cycles
    rep_a[15:8] = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      probe();
      check("a_flt_y", 32'(y_a), 32'hA5);
      check("a_flt_min", 32'(min_a), 32'h1);
      check("a_flt_mask", 32'(mask_a), 32'h0);
      check("a_flt_req", 32'(req_a), 32'h0);
      step();
    end
    probe();
    check("a_q_req", 32'(req_a), 32'b010);
    check("a_q_mask", 32'(mask_a), 32'b010);
    check("a_q_active", 32'(act_a), 32'd2);
    check("a_q_y", 32'(y_a), 32'hA5);
    check("a_q_min", 32'(min_a), 32'h0);
    check("a_q_sticky", 32'(stk_a), 32'b01);
    step();

    // Scrub ack and rejoin after eight agreeing cycles
    rep_a = {3{8'hA5}}; ack_a = 3'b010; clr_a = 1'b1;
    step();
    ack_a = 3'b000; clr_a = 1'b0;
    probe();
    check("a_ack_occ", 32'(occ_a), 32'h1);
    check("a_ack_req", 32'(req_a), 32'h0);
    check("a_ack_mask", 32'(mask_a), 32'b010);
    check("a_clr_sticky", 32'(stk_a), 32'h0);
    step();
    for (int i = 8; i <= 14; i++) begin
      probe();
      check("a_rj_occ", 32'(occ_a), 32'h0);
      check("a_rj_mask", 32'(mask_a), 32'b010);
      step();
    end
    probe();
    check("a_rj_done_mask", 32'(mask_a), 32'h0);
    check("a_rj_done_active", 32'(act_a), 32'd3);
    step();

    // B: replicas 0 and 2 faulty, only one may leave
    rep_b[7:0] = 8'hC3; rep_b[23:16] = 8'hC3;
    for (int i = 1; i <= 4; i++) begin
      probe();
      check("b_flt_y", 32'(y_b), 32'h3C);
      check("b_flt_min", 32'(min_b), 32'h1);
      check("b_flt_mask", 32'(mask_b), 32'h0);
      step();
    end
    probe();
    check("b_q_mask", 32'(mask_b), 32'b00001);
    check("b_q_req", 32'(req_b), 32'b00001);
    check("b_q_active", 32'(act_b), 32'd4);
    check("b_q_y", 32'(y_b), 32'h3C);
    step();
    probe();
    check("b_inhib_mask", 32'(mask_b), 32'b00001);
    check("b_inhib_active", 32'(act_b), 32'd4);
    check("b_inhib_min", 32'(min_b), 32'h1);
    step();
    rep_b = {5{8'h3C}};

    // C: two-replica tie with hold
    probe();
    check("c_agree_y", 32'(y_c), 32'h33);
    check("c_agree_maj", 32'(maj_c), 32'h0);
    step();
    rep_c = {8'hF0, 8'h0F};
    probe();
    check("c_tie_maj", 32'(maj_c), 32'h1);
    check("c_tie_y", 32'(y_c), 32'h33);
    check("c_tie_min", 32'(min_c), 32'h0);
    step();
    clr_c = 1'b1;
    probe();
    check("c_tie_sticky", 32'(stk_c), 32'b10);
    check("c_tie_hold_y", 32'(y_c), 32'h33);
    step();
    rep_c = {2{8'h55}};
    probe();
    check("c_clr_vs_err", 32'(stk_c), 32'b10);
    check("c_new_y", 32'(y_c), 32'h55);
    check("c_new_maj", 32'(maj_c), 32'h0);
    check("c_no_quar", 32'(mask_c), 32'h0);
    step();
    clr_c = 1'b0;
    probe();
    check("c_cleared", 32'(stk_c), 32'h0);
    step();

    // A: reset while a scrub request is pending
    rep_a[23:16] = 8'h00;
    repeat (4) step();
    probe();
    check("a_pend_req", 32'(req_a), 32'b100);
    check("a_pend_mask", 32'(mask_a), 32'b100);
    rst_i = 1'b1; ack_a = 3'b100;
    step();
    rst_i = 1'b0; ack_a = 3'b000; rep_a = {3{8'hA5}};
    probe();
    check("a_rrst_req", 32'(req_a), 32'h0);
    check("a_rrst_mask", 32'(mask_a), 32'h0);
    check("a_rrst_active", 32'(act_a), 32'd3);
    check("a_rrst_occ", 32'(occ_a), 32'h0);
    step();
    // Fresh counter: three mismatches must not quarantine
    for (int i = 0; i < 3; i++) begin
      rep_a[23:16] = 8'h00;
      probe();
      check("a_rrst_cnt", 32'(mask_a), 32'h0);
      step();
    end
    rep_a = {3{8'hA5}};
    probe();
    check("a_rrst_cnt_end", 32'(mask_a), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
